debug_dump_ctrl: RTL and testbench

Host-side controller for the RV32core debug port; it drives the side of the interface that the core receives. It generates single-step pulses from a button level and sweeps debug_addr across the core's debug register space. Each 32-bit debug_data word is captured and streamed out as bytes over a valid/ready link, normally to a UART transmitter. It sits between the board I/O (button, UART) and the core's debug_* ports.

---
 rtl/debug_dump_ctrl.sv | 144 ++++++++++++++
 tb/tb_debug_dump_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_ctrl.sv
// Host-side debug port controller: single-step pulses and a register dump streamed as bytes.
// Define DUMP_HEADER_EN to prefix every word with a {1'b1, addr[6:0]} header byte.
module debug_dump_ctrl #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned NUM_REGS = 64,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_req,
  input  logic              dump_req,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [31:0]       debug_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

`ifdef DUMP_HEADER_EN
  localparam int unsigned NUM_BYTES = 5;
`else
  localparam int unsigned NUM_BYTES = 4;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [2:0]        LAT       = 3'(READ_LAT);
  localparam logic [2:0]        LAST_BYTE = 3'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_SETADDR, S_WAIT, S_SEND, S_DONE
  } state_t;

  state_t      state;
  logic        step_q;
  logic [2:0]  wait_cnt;
  logic [2:0]  byte_idx;
  logic [31:0] word;

  logic [7:0]  first_byte_c;
  logic [31:0] first_word_c;

  // First byte presented at capture; word holds the remaining bytes, next one in [31:24]
  always_comb begin
    first_byte_c = debug_data[31:24];
    first_word_c = {debug_data[23:0], 8'h00};
`ifdef DUMP_HEADER_EN
    first_byte_c = {1'b1, 7'(debug_addr)};
    first_word_c = debug_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      step_q     <= 1'b0;
      wait_cnt   <= '0;
      byte_idx   <= '0;
      word       <= '0;
      debug_en   <= 1'b0;
      debug_step <= 1'b0;
      debug_addr <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      step_q <= step_req;
      case (state)
        S_IDLE: begin
          // A dump request takes priority; a simultaneous step edge is dropped
          if (dump_req) begin
            state      <= S_SETADDR;
            debug_addr <= '0;
            debug_en   <= 1'b1;
            busy       <= 1'b1;
          end else if (step_req && !step_q) begin
            state      <= S_STEP;
            debug_step <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_STEP: begin
          debug_step <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        S_SETADDR: begin
          wait_cnt <= LAT;
          byte_idx <= '0;
          if (READ_LAT == 0) begin
            tx_data  <= first_byte_c;
            word     <= first_word_c;
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 3'd1) begin
            tx_data  <= first_byte_c;
            word     <= first_word_c;
            tx_valid <= 1'b1;
            state    <= S_SEND;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        S_SEND: begin
          // tx_valid is always high here, so tx_ready alone marks the handshake
          if (tx_ready) begin
            if (byte_idx == LAST_BYTE) begin
              tx_valid <= 1'b0;
              if (debug_addr == LAST_ADDR) begin
                state      <= S_DONE;
                done       <= 1'b1;
                debug_en   <= 1'b0;
                debug_addr <= '0;
              end else begin
                debug_addr <= debug_addr + ADDR_W'(1);
                state      <= S_SETADDR;
              end
            end else begin
              tx_data  <= word[31:24];
              word     <= {word[23:0], 8'h00};
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_ctrl.sv
// Bench for debug_dump_ctrl: step pulses, byte-stream dumps with backpressure, abort on reset.
module tb_debug_dump_ctrl;
  localparam int ADDR_W   = 7;
  localparam int NUM_REGS = 4;
  localparam int READ_LAT = 1;
`ifdef DUMP_HEADER_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic              clk;
  logic              rst;
  logic              step_req;
  logic              dump_req;
  logic              debug_en;
  logic              debug_step;
  logic [ADDR_W-1:0] debug_addr;
  logic [31:0]       debug_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  logic [31:0] base;
  bit          const_mode;
  logic [31:0] rd_q;

  debug_dump_ctrl #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst), .step_req(step_req), .dump_req(dump_req),
    .debug_en(debug_en), .debug_step(debug_step), .debug_addr(debug_addr),
    .debug_data(debug_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core-side register file model with one cycle of read latency
  always_ff @(posedge clk) rd_q <= const_mode ? base : base + 32'(debug_addr);
  assign debug_data = rd_q;

  task automatic push_dump(input logic [31:0] b, input bit cm);
    logic [31:0] d;
    for (int a = 0; a < NUM_REGS; a++) begin
      d = cm ? b : b + 32'(a);
`ifdef DUMP_HEADER_EN
      exp_q.push_back({1'b1, 7'(a)});
`endif
      exp_q.push_back(d[31:24]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
    end
  endtask

  task automatic test_reset();
    logic [24:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs = {debug_en, debug_step, 7'(debug_addr), tx_data, tx_valid, busy, done};
    checks++;
    if (outs !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h expected=0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, tx_valid, debug_step, debug_en} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset_idle got=%b expected=0000", {busy, tx_valid, debug_step, debug_en});
    end
  endtask

  task automatic test_step();
    int pulses;
    repeat (4) @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({debug_step, busy} !== 2'b11) begin
      errors++;
      $display("FAIL step_pulse got=%b expected=11", {debug_step, busy});
    end
    @(negedge clk);
    checks++;
    if ({debug_step, busy} !== 2'b00) begin
      errors++;
      $display("FAIL step_end got=%b expected=00", {debug_step, busy});
    end
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (debug_step) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL step_held got=%0d pulses expected=0", pulses);
    end
    step_req = 1'b0;
    @(negedge clk);
  endtask

  // Runs one full dump; optional ready toggling and step pokes during the dump
  task automatic test_dump(input logic [31:0] b, input bit cm, input bit toggle, input bit poke);
    int first_valid, done_cnt, done_cyc, bad_en, bad_step, bad_hold;
    bit hold;
    logic [7:0] hold_data, exp;
    first_valid = -1; done_cnt = 0; done_cyc = -1;
    bad_en = 0; bad_step = 0; bad_hold = 0; hold = 1'b0; hold_data = '0;
    base = b; const_mode = cm; tx_ready = 1'b1; step_req = 1'b0;
    exp_q.delete();
    push_dump(b, cm);
    @(negedge clk);
    dump_req = 1'b1;
    if (poke) step_req = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      dump_req = 1'b0;
      if (toggle) tx_ready = ~tx_ready;
      if (poke && done_cyc < 0) step_req = ((c % 4) >= 2);
      if (debug_step) bad_step++;
      if (hold && (!tx_valid || tx_data !== hold_data)) bad_hold++;
      hold = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid && first_valid < 0) first_valid = c;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        if (debug_en !== 1'b0 || debug_addr !== '0) bad_en++;
      end else if (done_cyc < 0 && debug_en !== 1'b1) begin
        bad_en++;
      end
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_extra got=%h expected=none", tx_data);
        end else begin
          exp = exp_q.pop_front();
          if (tx_data !== exp) begin
            errors++;
            $display("FAIL byte_value got=%h expected=%h cycle=%0d", tx_data, exp, c);
          end
        end
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    checks++;
    if (done_cnt != 1 || done_cyc < 0) begin
      errors++;
      $display("FAIL done_pulses got=%0d expected=1", done_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bytes_missing got=%0d left expected=0", exp_q.size());
    end
    checks++;
    if (first_valid != READ_LAT + 1) begin
      errors++;
      $display("FAIL first_byte_latency got=%0d expected=%0d", first_valid, READ_LAT + 1);
    end
    if (!toggle) begin
      checks++;
      if (done_cyc != NUM_REGS * (READ_LAT + 1 + NB)) begin
        errors++;
        $display("FAIL dump_duration got=%0d expected=%0d", done_cyc, NUM_REGS * (READ_LAT + 1 + NB));
      end
    end
    checks++;
    if (bad_en != 0) begin
      errors++;
      $display("FAIL debug_en_window got=%0d bad cycles expected=0", bad_en);
    end
    checks++;
    if (bad_step != 0) begin
      errors++;
      $display("FAIL step_during_dump got=%0d pulses expected=0", bad_step);
    end
    checks++;
    if (bad_hold != 0) begin
      errors++;
      $display("FAIL tx_hold_stable got=%0d violations expected=0", bad_hold);
    end
    checks++;
    if ({busy, tx_valid, debug_en, 7'(debug_addr)} !== 10'd0) begin
      errors++;
      $display("FAIL after_dump_idle got=%b expected=0", {busy, tx_valid, debug_en, 7'(debug_addr)});
    end
    tx_ready = 1'b1;
    step_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    int hs, target;
    bit armed, fired;
    hs = 0; armed = 1'b0; fired = 1'b0;
    target = 2 * NB + NB - 3;
    base = 32'h1000_0000; const_mode = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    dump_req = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      dump_req = 1'b0;
      if (armed) begin
        tx_ready = 1'b0;
        checks++;
        if ({tx_valid, 7'(debug_addr), tx_data} !== {1'b1, 7'd2, 8'h00}) begin
          errors++;
          $display("FAIL pending_byte got=%h expected=%h", {tx_valid, 7'(debug_addr), tx_data}, {1'b1, 7'd2, 8'h00});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({tx_valid, 7'(debug_addr), debug_en, busy, done} !== 11'd0) begin
          errors++;
          $display("FAIL abort_state got=%b expected=0", {tx_valid, 7'(debug_addr), debug_en, busy, done});
        end
        fired = 1'b1;
        break;
      end
      if (tx_valid && tx_ready) begin
        hs++;
        if (hs == target) armed = 1'b1;
      end
    end
    checks++;
    if (!fired) begin
      errors++;
      $display("FAIL abort_reached got=%0d handshakes expected=%0d", hs, target);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    test_dump(32'h1000_0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; dump_req = 1'b0; step_req = 1'b0; tx_ready = 1'b1;
    base = '0; const_mode = 1'b0;
    test_reset();
    test_step();
    test_dump(32'h1000_0000, 1'b0, 1'b0, 1'b0);
    test_dump(32'h1000_0000, 1'b0, 1'b1, 1'b0);
    test_dump(32'h1000_0000, 1'b0, 1'b0, 1'b1);
    test_reset_mid();
    test_dump(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
